pc_redirect_ctrl: RTL

//  Owns the fetch PC register and sequences every next-PC source: sequential, branch/jump, exception entry, ERET return, stall hold.

---
 rtl/pc_redirect_ctrl_pkg.sv | 30 +++
 rtl/pc_redirect_ctrl_pc_next_sel.sv | 51 +++++
 rtl/pc_redirect_ctrl.sv | 133 +++++++++++++
 3 files changed

// File: rtl/pc_redirect_ctrl_pkg.sv
// Shared definitions for the fetch PC redirect controller: default vectors,
// FSM state encodings, next-PC select codes and the fetch-address check helper.
package pc_redirect_ctrl_pkg;

   localparam logic [31:0] RESET_PC_DEF     = 32'h0000_3000;
   localparam logic [31:0] EXC_VECTOR_DEF   = 32'h0000_4180;
   localparam logic [2:0]  FLUSH_CYCLES_DEF = 3'd1;
   localparam logic [31:0] IMEM_LO          = 32'h0000_3000;
   localparam logic [31:0] IMEM_HI          = 32'h0000_6FFF;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_HOLD  = 2'd1,
      ST_FLUSH = 2'd2
   } state_e;

   typedef enum logic [2:0] {
      SEL_EXC  = 3'd0,
      SEL_ERET = 3'd1,
      SEL_HOLD = 3'd2,
      SEL_BR   = 3'd3,
      SEL_SEQ  = 3'd4
   } sel_e;

   // Fetch address is bad when misaligned or outside the instruction memory window
   function automatic logic pc_addr_err(input logic [31:0] pc);
      pc_addr_err = (pc[1:0] != 2'b00) || (pc < IMEM_LO) || (pc > IMEM_HI);
   endfunction

endpackage

// File: rtl/pc_redirect_ctrl_pc_next_sel.sv
// Fixed-priority next-PC multiplexer: exception > ERET > flush-sequential >
// stall hold > branch > sequential. Purely combinational.
module pc_redirect_ctrl_pc_next_sel
   import pc_redirect_ctrl_pkg::*;
#(
   parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF
) (
   input  logic [31:0] pc,
   input  logic        bd_cur,
   input  logic        in_flush,
   input  logic        exc_req,
   input  logic        eret_req,
   input  logic        stall,
   input  logic        br_req,
   input  logic [31:0] br_target,
   input  logic [31:0] epc,
   output logic [31:0] pc_next,
   output logic        bd_next,
   output sel_e        sel
);

   // Priority select of the next fetch address and delay-slot flag
   always_comb begin
      pc_next = pc + 32'd4;
      bd_next = 1'b0;
      sel     = SEL_SEQ;
      if (exc_req) begin
         pc_next = EXC_VECTOR;
         sel     = SEL_EXC;
      end else if (eret_req) begin
         pc_next = epc;
         sel     = SEL_ERET;
      end else if (in_flush) begin
         // stall and branch requests come from killed instructions here
         pc_next = pc + 32'd4;
         sel     = SEL_SEQ;
      end else if (stall) begin
         pc_next = pc;
         bd_next = bd_cur;
         sel     = SEL_HOLD;
      end else if (br_req) begin
         pc_next = br_target;
         bd_next = 1'b1;
         sel     = SEL_BR;
      end else begin
         pc_next = pc + 32'd4;
         sel     = SEL_SEQ;
      end
   end

endmodule

// File: rtl/pc_redirect_ctrl.sv
// Fetch PC register, redirect FSM (RUN/HOLD/FLUSH) and IF/ID flush generation.
// Optional fetch address check output adel_o when PC_ALIGN_CHK_EN is defined.
module pc_redirect_ctrl
   import pc_redirect_ctrl_pkg::*;
#(
   parameter logic [31:0] RESET_PC     = RESET_PC_DEF,
   parameter logic [31:0] EXC_VECTOR   = EXC_VECTOR_DEF,
   parameter logic [2:0]  FLUSH_CYCLES = FLUSH_CYCLES_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall_i,
   input  logic        br_req_i,
   input  logic [31:0] br_target_i,
   input  logic        exc_req_i,
   input  logic        eret_req_i,
   input  logic [31:0] epc_i,
   output logic [31:0] pc_o,
   output logic [31:0] pc8_o,
   output logic        flush_o,
   output logic        bd_o,
`ifdef PC_ALIGN_CHK_EN
   output logic        adel_o,
`endif
   output logic [1:0]  state_o
);

   logic [31:0] pc_r;
   logic [31:0] pc8_r;
   logic        bd_r;
   logic        flush_r;
   state_e      state_r;
   logic [2:0]  cnt_r;

   logic [31:0] pc_next_s;
   logic        bd_next_s;
   sel_e        sel_s;
   logic        redirect_s;
   state_e      state_nxt_s;
   logic [2:0]  cnt_nxt_s;
   logic [2:0]  cnt_dec_s;
   logic        flush_nxt_s;

   pc_redirect_ctrl_pc_next_sel #(
      .EXC_VECTOR (EXC_VECTOR)
   ) u_pc_next_sel (
      .pc        (pc_r),
      .bd_cur    (bd_r),
      .in_flush  (state_r == ST_FLUSH),
      .exc_req   (exc_req_i),
      .eret_req  (eret_req_i),
      .stall     (stall_i),
      .br_req    (br_req_i),
      .br_target (br_target_i),
      .epc       (epc_i),
      .pc_next   (pc_next_s),
      .bd_next   (bd_next_s),
      .sel       (sel_s)
   );

   assign redirect_s = (sel_s == SEL_EXC) || (sel_s == SEL_ERET);
   assign cnt_dec_s  = (cnt_r != 3'd0) ? (cnt_r - 3'd1) : 3'd0;

   // FSM next state, flush counter and registered flush value
   always_comb begin
      state_nxt_s = state_r;
      cnt_nxt_s   = cnt_r;
      flush_nxt_s = 1'b0;
      if (redirect_s) begin
         state_nxt_s = ST_FLUSH;
         cnt_nxt_s   = FLUSH_CYCLES;
         flush_nxt_s = 1'b1;
      end else begin
         case (state_r)
            ST_RUN, ST_HOLD: begin
               state_nxt_s = stall_i ? ST_HOLD : ST_RUN;
               cnt_nxt_s   = 3'd0;
            end
            ST_FLUSH: begin
               // flush_o stays up until the reloaded count has been consumed
               cnt_nxt_s   = cnt_dec_s;
               flush_nxt_s = (cnt_dec_s != 3'd0);
               state_nxt_s = (cnt_dec_s == 3'd0) ? ST_RUN : ST_FLUSH;
            end
            default: begin
               state_nxt_s = ST_RUN;
               cnt_nxt_s   = 3'd0;
            end
         endcase
      end
   end

   // PC, link address, delay-slot flag and FSM registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_r    <= RESET_PC;
         pc8_r   <= RESET_PC + 32'd8;
         bd_r    <= 1'b0;
         flush_r <= 1'b0;
         state_r <= ST_RUN;
         cnt_r   <= 3'd0;
      end else begin
         pc_r    <= pc_next_s;
         pc8_r   <= pc_next_s + 32'd8;
         bd_r    <= bd_next_s;
         flush_r <= flush_nxt_s;
         state_r <= state_nxt_s;
         cnt_r   <= cnt_nxt_s;
      end
   end

`ifdef PC_ALIGN_CHK_EN
   logic adel_r;

   // Address error flag registered alongside the PC it describes
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         adel_r <= 1'b0;
      end else begin
         adel_r <= pc_addr_err(pc_next_s);
      end
   end

   assign adel_o = adel_r;
`endif

   assign pc_o    = pc_r;
   assign pc8_o   = pc8_r;
   assign bd_o    = bd_r;
   assign flush_o = flush_r;
   assign state_o = state_r;

endmodule
